// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Output-side companion of matrix_alu. A start strobe tells this block that
//   a new op has gone into the ALU. It waits out the ALU result latency,
//   captures the wide C bus once, and then plays the used part of it out one
//   word per beat over a valid/ready stream. The first beat is the MSB word.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      pulse: a new op was issued; taken only while busy is low
//   op         ALU opcode, sampled with start (2'b11 = kron, the rest are elementwise)
//   C          matrix_alu result bus, NA*NB words of word_size bits
//   out_data   current result element
//   out_valid  out_data is valid
//   out_ready  sink takes out_data this cycle
//   out_last   asserted with the final element
//   out_index  element number of out_data, 0-based
//   busy       high from accepted start until the final beat is taken
module matrix_result_streamer #(
    parameter int word_size     = 8,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2,
    parameter int ALU_LAT       = 2,
    localparam int NA    = Amatrixrownum * Amatrixcolnum,
    localparam int NB    = Bmatrixrownum * Bmatrixcolnum,
    localparam int NE    = NA * NB,
    localparam int CW    = NE * word_size,
    localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [CW-1:0]        C,
    output logic [word_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [IDX_W-1:0]     out_index,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAP,
        S_STREAM
    } state_t;

    // Wait counter is loaded with ALU_LAT-1 and exits at zero, so the WAIT
    // state lasts exactly ALU_LAT cycles.
    localparam logic [3:0]       LAT_M1 = 4'((ALU_LAT > 0) ? (ALU_LAT - 1) : 0);
    localparam logic [IDX_W-1:0] LAST_A = IDX_W'(NA - 1);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NE - 1);

    state_t                 r_state;
    logic [3:0]             r_wait;
    logic [CW-1:0]          r_cap;
    logic [IDX_W-1:0]       r_k;
    logic [IDX_W-1:0]       r_last_k;   // N-1 for the op in flight
    logic [word_size-1:0]   r_data;
    logic                   r_valid;
    logic                   r_olast;
    logic                   r_busy;

    logic                   w_xfer;
    logic [IDX_W-1:0]       w_next_k;
    logic [IDX_W-1:0]       w_next_pos;

    // Word at position pos counted from the LSB end of the bus.
    function automatic logic [word_size-1:0] pick(input logic [CW-1:0]    bus,
                                                  input logic [IDX_W-1:0] pos);
        logic [CW-1:0] sh;
        sh   = bus >> (int'(pos) * word_size);
        pick = sh[word_size-1:0];
    endfunction

    always_comb begin
        w_xfer     = r_valid & out_ready;
        w_next_k   = r_k + 1'b1;
        // Stream is MSB-first inside the used part: element k sits at N-1-k.
        w_next_pos = r_last_k - w_next_k;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_wait   <= '0;
            r_cap    <= '0;
            r_k      <= '0;
            r_last_k <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_olast  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last_k <= (op == 2'b11) ? LAST_K : LAST_A;
                        r_busy   <= 1'b1;
                        if (ALU_LAT == 0) begin
                            r_state <= S_CAP;
                        end else begin
                            r_wait  <= LAT_M1;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait == 4'd0) r_state <= S_CAP;
                    else                r_wait  <= r_wait - 4'd1;
                end
                S_CAP: begin
                    // Element 0 comes straight off C so it is ready the same
                    // edge the snapshot is taken.
                    r_cap   <= C;
                    r_k     <= '0;
                    r_data  <= pick(C, r_last_k);
                    r_olast <= (r_last_k == '0);
                    r_valid <= 1'b1;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (r_k == r_last_k) begin
                            r_valid <= 1'b0;
                            r_olast <= 1'b0;
                            r_busy  <= 1'b0;
                            r_k     <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_k     <= w_next_k;
                            r_data  <= pick(r_cap, w_next_pos);
                            r_olast <= (w_next_k == r_last_k);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_olast;
    assign out_index = r_k;
    assign busy      = r_busy;

endmodule

// File: tb/tb_matrix_result_streamer.sv
module tb_matrix_result_streamer;

    localparam int WS  = 8;
    localparam int NE  = 16;
    localparam int CW  = NE * WS;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [CW-1:0] C = '0;
    logic          out_ready = 1'b0;
    logic [WS-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic [3:0]    out_index;
    logic          busy;

    matrix_result_streamer #(.ALU_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .C(C),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_index(out_index), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WS-1:0] d;
        int            idx;
        logic          last;
    } beat_t;
    beat_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a result of N words is the low N words of C, read out
    // from the most significant one down.
    task automatic push_expect(input logic [1:0] o, input logic [CW-1:0] c);
        int    n;
        beat_t b;
        n = (o == 2'b11) ? 16 : 4;
        for (int k = 0; k < n; k++) begin
            b.d    = WS'((c >> ((n - 1 - k) * WS)) & 128'hFF);
            b.idx  = k;
            b.last = (k == n - 1);
            sb.push_back(b);
        end
    endtask

    // out_ready driver: 0 = always high, 1 = random, 2 = pattern 1,0,0
    int rdy_mode = 0;
    int rcnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (rcnt % 3 == 0);
        endcase
        rcnt++;
    end

    // Monitor: pops expected beats on every transfer and checks hold rules.
    logic          pstall = 1'b0;
    logic [WS-1:0] pd;
    logic [3:0]    pi;
    logic          pl;
    beat_t         mb;
    always @(negedge clk) begin
        if (!resetn) begin
            pstall = 1'b0;
        end else begin
            if (pstall) begin
                chk("hold_valid", 128'(out_valid), 128'(1'b1));
                chk("hold_data", 128'(out_data), 128'(pd));
                chk("hold_index", 128'(out_index), 128'(pi));
                chk("hold_last", 128'(out_last), 128'(pl));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat data=%0h index=%0d expected no beat", out_data, out_index);
                end else begin
                    mb = sb.pop_front();
                    chk("beat_data", 128'(out_data), 128'(mb.d));
                    chk("beat_index", 128'(out_index), 128'(mb.idx));
                    chk("beat_last", 128'(out_last), 128'(mb.last));
                end
            end
            pstall = out_valid && !out_ready;
            pd = out_data;
            pi = out_index;
            pl = out_last;
        end
    end

    // Issues an op (expects acceptance), checks busy and first-beat latency.
    task automatic issue(input logic [1:0] o, input logic [CW-1:0] c);
        int t0;
        int n;
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        C     = c;
        push_expect(o, c);
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1'b1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 30);
        chk("first_valid_latency", 128'(cyc - t0), 128'(LAT + 2));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || out_valid || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL idle_timeout busy=%0b valid=%0b pending=%0d", busy, out_valid, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic pulse_ignored(input logic [1:0] o);
        @(posedge clk);
        #1;
        chk("busy_during_ignored_start", 128'(busy), 128'(1'b1));
        start = 1'b1;
        op    = o;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [CW-1:0] rand_c();
        logic [CW-1:0] c;
        for (int i = 0; i < CW / 32; i++) c[i*32 +: 32] = $urandom;
        return c;
    endfunction

    initial begin
        logic [CW-1:0] c;
        int            n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_last", 128'(out_last), 128'(1'b0));
        chk("rst_index", 128'(out_index), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // add: upper bits random and irrelevant
        rdy_mode = 0;
        c = rand_c();
        c[31:0] = 32'h06080A08;
        issue(2'b00, c);
        wait_idle(100);
        chk("busy_after_add", 128'(busy), 128'(1'b0));

        // mul with stalling sink
        rdy_mode = 2;
        c = rand_c();
        c[31:0] = 32'h13160F12;
        issue(2'b10, c);
        wait_idle(100);

        // kron: 16 words 00..0F, MSW first
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) c[(15 - i) * WS +: WS] = WS'(i);
        issue(2'b11, c);
        wait_idle(100);

        // start while busy is ignored
        issue(2'b01, rand_c());
        pulse_ignored(2'b11);
        wait_idle(100);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle_after_ignored_start", 128'({busy, out_valid}), 128'(2'b00));
        end

        // C changes after capture do not disturb the stream
        issue(2'b11, rand_c());
        @(posedge clk);
        #1;
        C = '1;
        wait_idle(100);

        // Reset mid-stream at k=2
        issue(2'b11, rand_c());
        n = 0;
        while (!(out_valid && out_index == 4'd2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reached_k2", 128'(out_index), 128'(2));
        #2;
        resetn = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_index", 128'(out_index), 128'(0));
        chk("midrst_data", 128'(out_data), 128'(0));
        chk("midrst_last", 128'(out_last), 128'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_beat_after_reset", 128'({busy, out_valid}), 128'(2'b00));
        end

        // Randomized ops with random backpressure and stray starts
        rdy_mode = 1;
        for (int it = 0; it < 40; it++) begin
            issue(2'($urandom_range(0, 3)), rand_c());
            if ($urandom_range(0, 2) == 0) pulse_ignored(2'($urandom_range(0, 3)));
            wait_idle(300);
        end

        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
